// File: rtl/arith_pkg.sv
// arith_pkg: op encodings, FSM state encodings and parameter legality check for arith_unit_seq
package arith_pkg;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    function automatic bit params_ok(input int width, input int digit);
        return width >= 2 && digit >= 1 && digit <= width && width % digit == 0;
    endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit ripple adder; a, b, cin in; sum, cout out
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: digit-serial add/sub/accumulate unit with start/done handshake
// clk/rst (async, active-high); start_in, op_in, a_in, b_in, acc_clr_in in;
// busy_out, done_out, y_out (carry in bit WIDTH), ovf_out, zero_out, acc_out out (all registered)
module arith_unit_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             acc_clr_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH:0]   y_out,
    output logic             ovf_out,
    output logic             zero_out,
    output logic [WIDTH-1:0] acc_out
);
    localparam bit PARAMS_OK = params_ok(WIDTH, DIGIT);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    if (!PARAMS_OK) begin : g_bad_params
        $error("arith_unit_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt, a_sel, b_sel;
    logic             carry, a_msb, b_msb, acc_op;
    logic             op_sub, op_acc, last;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    digit_adder #(.DIGIT(DIGIT)) u_add (
        .a(a_r[DIGIT-1:0]),
        .b(b_r[DIGIT-1:0]),
        .cin(carry),
        .sum(dsum),
        .cout(dcout)
    );
    always_comb begin
        op_sub  = op_in == OP_SUB || op_in == OP_ACC_SUB;
        op_acc  = op_in == OP_ACC_ADD || op_in == OP_ACC_SUB;
        // clear wins over the accumulator as the A operand on the same cycle
        a_sel   = op_acc ? (acc_clr_in ? '0 : acc_out) : a_in;
        b_sel   = op_sub ? ~b_in : b_in;
        last    = cnt == CW'(N - 1);
        // sum digits enter at the top and shift down, landing in place after N steps
        sum_nxt = (sum_r >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            acc_op   <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            y_out    <= '0;
            ovf_out  <= 1'b0;
            zero_out <= 1'b0;
            acc_out  <= '0;
        end else begin
            done_out <= 1'b0;
            if (state == ST_IDLE) begin
                if (acc_clr_in) acc_out <= '0;
                if (start_in) begin
                    a_r      <= a_sel;
                    b_r      <= b_sel;
                    a_msb    <= a_sel[WIDTH-1];
                    b_msb    <= b_sel[WIDTH-1];
                    carry    <= op_sub;
                    cnt      <= '0;
                    acc_op   <= op_acc;
                    busy_out <= 1'b1;
                    state    <= ST_RUN;
                end
            end else if (state == ST_RUN) begin
                a_r   <= a_r >> DIGIT;
                b_r   <= b_r >> DIGIT;
                carry <= dcout;
                sum_r <= sum_nxt;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    y_out    <= {dcout, sum_nxt};
                    ovf_out  <= (a_msb == b_msb) && (dsum[DIGIT-1] != a_msb);
                    zero_out <= sum_nxt == '0;
                    done_out <= 1'b1;
                    if (acc_op) acc_out <= sum_nxt;
                    state    <= ST_DONE;
                end
            end else begin
                busy_out <= 1'b0;
                state    <= ST_IDLE;
            end
        end
    end
endmodule

// File: doc/arith_unit_seq.md
# arith_unit_seq

Parametrised, digit-serial add/subtract/accumulate unit with a start/done handshake. Generalises the team's 8-bit add/sub block (subtract as A + ~B + 1, carry-out as MSB of result) to WIDTH bits and adds an internal accumulator, signed-overflow and zero flags, and multi-cycle evaluation in DIGIT-bit slices. It sits beside the datapath as a small-area arithmetic engine for controllers that can tolerate WIDTH/DIGIT + 1 cycles of latency.

## Interface
Parameters:
- WIDTH, 16, operand/accumulator width; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  request; accepted only when busy_out = 0.
- op_in  in  2  00 ADD (A+B), 01 SUB (A−B), 10 ACC_ADD (ACC+B), 11 ACC_SUB (ACC−B).
- a_in  in  WIDTH  operand A; ignored for ACC ops.
- b_in  in  WIDTH  operand B.
- acc_clr_in  in  1  clear accumulator; honoured only when busy_out = 0.
- busy_out  out  1  high from the cycle after acceptance until done.
- done_out  out  1  one-cycle pulse when results become valid.
- y_out  out  WIDTH+1  result; bit WIDTH = carry-out.
- ovf_out  out  1  signed (two's-complement) overflow.
- zero_out  out  1  y_out[WIDTH-1:0] == 0.
- acc_out  out  WIDTH  current accumulator.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start_in=1 → latch A operand (a_in, or ACC for ops 1x), latch B (b_in, or ~b_in for op[0]=1), carry ← op[0], digit count ← 0, op latched; go to RUN.
- RUN: each cycle add digit `count` of A, B and carry; store sum digit, update carry; after digit N−1 go to DONE.
- DONE: register y_out = {carry, sum}, ovf_out = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]) with B' the possibly inverted operand, zero_out; pulse done_out; if op[1]=1, ACC ← sum[WIDTH-1:0]. Next state IDLE.
- Subtract carry-out is 1 when A ≥ B unsigned (no borrow).
- start_in while busy: ignored, no queuing; operands must be held only on the accepting cycle.
- acc_clr_in in IDLE: ACC ← 0 next edge. If asserted together with start_in of an ACC op, the op uses 0 as A (clear has priority).
- acc_clr_in while busy: ignored.
- y_out/ovf_out/zero_out hold last result until the next DONE.
- Reset mid-operation: immediate return to IDLE, all outputs and ACC cleared, in-flight op discarded.

## Timing
- Reset values: busy_out 0, done_out 0, y_out 0, ovf_out 0, zero_out 0, acc_out 0.
- Acceptance edge T0; busy_out high T0+1 through T0+N+1; done_out and results valid in cycle T0+N+1 (latency N+1; WIDTH=16, DIGIT=4 → 5).
- acc_out updates in the same cycle as done_out.
- Earliest next acceptance: the cycle after done_out (throughput one op per N+2 cycles).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package arith_pkg: op encodings (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB), FSM state encodings, parameter legality check constant.
- Sub-module digit_adder: DIGIT-bit ripple adder, inputs a, b, cin; outputs sum, cout. Instantiated once; the top holds shift/select, counter, FSM, flags and ACC.

## Test plan
WIDTH=16, DIGIT=4:
- ADD 0xFFFF + 0x0001 → y_out=0x1_0000, zero_out=1, ovf_out=0, done_out exactly 5 cycles after accept.
- SUB 0x0005 − 0x0007 → y_out=0x0_FFFE (carry 0), ovf_out=0; SUB 0x0007 − 0x0005 → y_out=0x1_0002.
- ADD 0x7FFF + 0x0001 → y_out=0x0_8000, ovf_out=1; SUB 0x8000 − 0x0001 → y_out=0x1_7FFF, ovf_out=1.
- acc_clr_in, then ACC_ADD 0x000A three times → acc_out=0x001E; ACC_SUB 0x001F → y_out=0x0_FFFF, acc_out=0xFFFF.
- start_in pulsed at accept+2 with different operands → ignored, single done_out with first result; acc_clr_in+ACC_ADD 0x0003 same cycle → acc_out=0x0003.
- rst asserted at accept+3 → busy_out, done_out, y_out, acc_out 0 immediately; no done_out afterwards.
